// File: rtl/matmul_engine.sv
// Matrix-product engine P = A*X: A rows streamed from a synchronous ROM are broadcast
// to LANES MAC lanes against a locally held K x LANES sample matrix X.
`timescale 1ns/1ps
module matmul_engine #(
    parameter int X_W    = 8,
    parameter int A_W    = 14,
    parameter int ACC_W  = 18,
    parameter int K      = 4,
    parameter int LANES  = 4,
    parameter int M      = 4,
    parameter int ADDR_W = 8,
    parameter int SAT    = 1,
    parameter int RA_W   = $clog2(M*K)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_load_en,
    input  logic                   valid_input,
    input  logic [X_W-1:0]         X_load,
    output logic                   xload_done,
    input  logic                   ALU_en,
    output logic [RA_W-1:0]        rom_addr,
    input  logic [A_W-1:0]         A_input,
    input  logic [ADDR_W-1:0]      wr_base,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [LANES*ACC_W-1:0] wr_data,
    output logic                   busy,
    output logic                   ALU_done
);

    localparam int K_W    = (K > 1) ? $clog2(K) : 1;
    localparam int M_W    = (M > 1) ? $clog2(M) : 1;
    localparam int L_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PROD_W = A_W + X_W;
    localparam int SUM_W  = PROD_W + ((K > 1) ? $clog2(K) : 0);
    // Accumulator is wide enough for the exact dot product, so overflow is never lost.
    localparam int ACC_INT_W = (SUM_W > ACC_W) ? SUM_W : ACC_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_reg;
    logic [K_W-1:0]    k_reg;
    logic [K_W-1:0]    k_d_reg;
    logic              acc_en_reg;
    logic [M_W-1:0]    m_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [RA_W-1:0]   rom_addr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              full_reg;
    logic [K_W-1:0]    ld_k_reg;
    logic [L_W-1:0]    ld_j_reg;
    logic [X_W-1:0]    x_mem [K][LANES];

    logic load_fire;
    logic last_slot;
    logic first_slot;

    assign load_fire  = input_load_en & valid_input & ~busy_reg & ~rst;
    assign last_slot  = (ld_k_reg == K_W'(K-1)) && (ld_j_reg == L_W'(LANES-1));
    assign first_slot = (ld_k_reg == '0) && (ld_j_reg == '0);
    assign xload_done = load_fire & last_slot;

    // Load pointer walks row-major (k outer, lane inner); a complete pass marks X full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_k_reg <= '0;
            ld_j_reg <= '0;
            full_reg <= 1'b0;
        end else if (load_fire) begin
            if (ld_j_reg == L_W'(LANES-1)) begin
                ld_j_reg <= '0;
                ld_k_reg <= last_slot ? '0 : ld_k_reg + K_W'(1);
            end else begin
                ld_j_reg <= ld_j_reg + L_W'(1);
            end
            if (last_slot)
                full_reg <= 1'b1;
            else if (first_slot)
                full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire)
            x_mem[ld_k_reg][ld_j_reg] <= X_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            k_reg        <= '0;
            k_d_reg      <= '0;
            acc_en_reg   <= 1'b0;
            m_reg        <= '0;
            base_reg     <= '0;
            rom_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            // ROM data lags the address by one cycle, so the accumulate tag lags too.
            acc_en_reg <= (state_reg == S_FETCH);
            k_d_reg    <= k_reg;
            case (state_reg)
                S_IDLE: begin
                    if (ALU_en && full_reg) begin
                        base_reg     <= wr_base;
                        m_reg        <= '0;
                        k_reg        <= '0;
                        rom_addr_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (k_reg == K_W'(K-1)) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        k_reg        <= k_reg + K_W'(1);
                        rom_addr_reg <= rom_addr_reg + RA_W'(1);
                    end
                end
                S_DRAIN: state_reg <= S_WRITE;
                S_WRITE: begin
                    if (wr_ready) begin
                        if (m_reg == M_W'(M-1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            // Address holds m*K+K-1 here, so the next row starts one above it.
                            m_reg        <= m_reg + M_W'(1);
                            k_reg        <= '0;
                            rom_addr_reg <= rom_addr_reg + RA_W'(1);
                            state_reg    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PROD_W-1:0]    prod;
            logic [ACC_INT_W-1:0] acc_reg;

            assign prod = PROD_W'(A_input) * PROD_W'(x_mem[k_d_reg][gi]);

            always_ff @(posedge clk) begin
                if (rst)
                    acc_reg <= '0;
                else if (acc_en_reg) begin
                    if (k_d_reg == '0)
                        acc_reg <= ACC_INT_W'(prod);
                    else
                        acc_reg <= acc_reg + ACC_INT_W'(prod);
                end
            end

            assign wr_data[gi*ACC_W +: ACC_W] =
                ((SAT != 0) && (|acc_reg[ACC_INT_W-1:ACC_W])) ? {ACC_W{1'b1}}
                                                             : acc_reg[ACC_W-1:0];
        end
    endgenerate

    assign wr_en    = (state_reg == S_WRITE);
    assign wr_addr  = base_reg + ADDR_W'(m_reg);
    assign rom_addr = rom_addr_reg;
    assign busy     = busy_reg;
    assign ALU_done = done_reg;

endmodule

// File: tb/tb_matmul_engine.sv
// Randomised scoreboard bench for matmul_engine: a saturating and a wrapping instance
// share all stimulus; expected rows come from a plain-arithmetic matrix product.
`timescale 1ns/1ps
module tb_matmul_engine;

    localparam int X_W    = 8;
    localparam int A_W    = 14;
    localparam int ACC_W  = 18;
    localparam int K      = 4;
    localparam int LANES  = 4;
    localparam int M      = 4;
    localparam int ADDR_W = 8;
    localparam int RA_W   = $clog2(M*K);
    localparam int NX     = K*LANES;
    localparam int DW     = LANES*ACC_W;
    localparam longint MAXV = (longint'(1) << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              input_load_en;
    logic              valid_input;
    logic [X_W-1:0]    X_load;
    logic              ALU_en;
    logic [A_W-1:0]    A_input;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_ready;

    logic              xload_done, wr_en, busy, ALU_done;
    logic [RA_W-1:0]   rom_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;

    logic              xload_done_w, wr_en_w, busy_w, ALU_done_w;
    logic [RA_W-1:0]   rom_addr_w;
    logic [ADDR_W-1:0] wr_addr_w;
    logic [DW-1:0]     wr_data_w;

    always #5 clk = ~clk;

    matmul_engine #(.X_W(X_W), .A_W(A_W), .ACC_W(ACC_W), .K(K), .LANES(LANES), .M(M),
                    .ADDR_W(ADDR_W), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .input_load_en(input_load_en), .valid_input(valid_input),
        .X_load(X_load), .xload_done(xload_done), .ALU_en(ALU_en), .rom_addr(rom_addr),
        .A_input(A_input), .wr_base(wr_base), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .ALU_done(ALU_done));

    matmul_engine #(.X_W(X_W), .A_W(A_W), .ACC_W(ACC_W), .K(K), .LANES(LANES), .M(M),
                    .ADDR_W(ADDR_W), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .input_load_en(input_load_en), .valid_input(valid_input),
        .X_load(X_load), .xload_done(xload_done_w), .ALU_en(ALU_en), .rom_addr(rom_addr_w),
        .A_input(A_input), .wr_base(wr_base), .wr_en(wr_en_w), .wr_ready(wr_ready),
        .wr_addr(wr_addr_w), .wr_data(wr_data_w), .busy(busy_w), .ALU_done(ALU_done_w));

    // Synchronous coefficient ROM shared by both instances.
    logic [A_W-1:0] rom [M*K];
    logic [X_W-1:0] x_ref [NX];
    always @(posedge clk) A_input <= rom[rom_addr];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     sat_d;
        logic [DW-1:0]     wrap_d;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_row(input int m, input bit sat);
        logic [DW-1:0] r;
        longint sum, v;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            sum = 0;
            for (int k = 0; k < K; k++)
                sum += longint'(rom[m*K+k]) * longint'(x_ref[k*LANES+j]);
            v = sat ? ((sum > MAXV) ? MAXV : sum) : (sum % (MAXV + 1));
            r[j*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic push_rows(input logic [ADDR_W-1:0] base, input int nrows);
        exp_t e;
        for (int m = 0; m < nrows; m++) begin
            e.addr   = ADDR_W'(base + m);
            e.sat_d  = model_row(m, 1'b1);
            e.wrap_d = model_row(m, 1'b0);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every accepted write must match the oldest expected row.
    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got write to %0h, expected none", wr_addr);
            end else begin
                mon_e = sb_q.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(mon_e.addr));
                check("wr_data_sat", 128'(wr_data), 128'(mon_e.sat_d));
                check("wrap_wr_en", 128'(wr_en_w), 128'(1));
                check("wrap_wr_addr", 128'(wr_addr_w), 128'(mon_e.addr));
                check("wr_data_wrap", 128'(wr_data_w), 128'(mon_e.wrap_d));
                $display("write addr=%0h sat=%0h wrap=%0h", wr_addr, wr_data, wr_data_w);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, 128'(wr_en), 128'(0));
        check({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
        check({tag, "_wr_data"}, 128'(wr_data), 128'(0));
        check({tag, "_rom_addr"}, 128'(rom_addr), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_alu_done"}, 128'(ALU_done), 128'(0));
        check({tag, "_xload_done"}, 128'(xload_done), 128'(0));
        check({tag, "_w_rom_addr"}, 128'(rom_addr_w), 128'(0));
        check({tag, "_w_busy"}, 128'(busy_w), 128'(0));
        check({tag, "_w_xload_done"}, 128'(xload_done_w), 128'(0));
    endtask

    // Loads x_ref[first..last] with random idle/partial cycles between samples.
    task automatic load_x(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                input_load_en = 1'($urandom);
                valid_input   = input_load_en ? 1'b0 : 1'($urandom);
                X_load        = X_W'($urandom);
                @(posedge clk); #1;
            end
            input_load_en = 1'b1;
            valid_input   = 1'b1;
            X_load        = x_ref[i];
            #1;
            check("xload_done", 128'(xload_done), 128'(i == NX-1));
            @(posedge clk); #1;
        end
        input_load_en = 1'b0;
        valid_input   = 1'b0;
    endtask

    task automatic run_matrix(input logic [ADDR_W-1:0] base, input bit stall, input bit disturb);
        int n;
        bit done, stalled;
        logic [ADDR_W-1:0] b1;
        logic [DW-1:0] row1;
        b1   = base + ADDR_W'(1);
        row1 = model_row(1, 1'b1);
        push_rows(base, M);
        wr_base = base;
        ALU_en  = 1'b1;
        @(posedge clk); #1;
        ALU_en  = 1'b0;
        wr_base = ADDR_W'($urandom);
        n = 0; done = 0; stalled = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (disturb && n == 3) begin
                ALU_en = 1'b1; input_load_en = 1'b1; valid_input = 1'b1; X_load = X_W'($urandom);
                #1;
                check("xload_while_busy", 128'(xload_done), 128'(0));
            end
            if (disturb && n == 5) begin
                ALU_en = 1'b0; input_load_en = 1'b0; valid_input = 1'b0;
            end
            if (ALU_done) begin
                done = 1;
                check("wrap_alu_done", 128'(ALU_done_w), 128'(1));
                check("busy_at_done", 128'(busy), 128'(1));
            end else if (stall && !stalled && wr_en && wr_addr == b1) begin
                stalled  = 1;
                wr_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    if (s > 0) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (s == 3) wr_ready = 1'b1;
                    check("stall_wr_en", 128'(wr_en), 128'(1));
                    check("stall_wr_addr", 128'(wr_addr), 128'(b1));
                    check("stall_wr_data", 128'(wr_data), 128'(row1));
                    check("stall_rom_addr", 128'(rom_addr), 128'(2*K-1));
                end
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL run_timeout: got no ALU_done, expected one within 400 cycles");
        end else begin
            check("start_to_done_cycles", 128'(n), 128'(24 + (stall ? 3 : 0)));
        end
        @(posedge clk); #1;
        check("busy_after_done", 128'(busy), 128'(0));
        check("alu_done_pulse", 128'(ALU_done), 128'(0));
        check("sb_empty", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic abort_run(input logic [ADDR_W-1:0] base);
        int n;
        push_rows(base, 2);
        wr_base = base;
        ALU_en  = 1'b1;
        @(posedge clk); #1;
        ALU_en = 1'b0;
        n = 0;
        while (!(busy && !wr_en && rom_addr == RA_W'(2*K)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_row2", 128'(rom_addr), 128'(2*K));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        check("abort_sb_empty", 128'(sb_q.size()), 128'(0));
        ALU_en = 1'b1;
        @(posedge clk); #1;
        ALU_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("start_ignored_after_abort", 128'(busy), 128'(0));
    endtask

    task automatic fill(input int amode, input int xmode);
        for (int i = 0; i < M*K; i++)
            case (amode)
                0: rom[i] = A_W'(1);
                1: rom[i] = A_W'(16383);
                2: rom[i] = A_W'((i / K) == (i % K));
                3: rom[i] = A_W'($urandom);
                default: rom[i] = A_W'($urandom_range(0, 255));
            endcase
        for (int i = 0; i < NX; i++)
            case (xmode)
                0: x_ref[i] = X_W'(1);
                1: x_ref[i] = X_W'(255);
                2: x_ref[i] = X_W'(10*(i / LANES) + (i % LANES));
                default: x_ref[i] = X_W'($urandom);
            endcase
    endtask

    initial begin
        rst = 1'b1; input_load_en = 1'b0; valid_input = 1'b0; X_load = '0;
        ALU_en = 1'b0; wr_base = '0; wr_ready = 1'b1;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // All ones, then the same X reused at a wrapping base address.
        fill(0, 0);
        load_x(0, NX-1);
        run_matrix(8'h10, 1'b0, 1'b0);
        run_matrix(8'hFE, 1'b0, 1'b0);

        // Full-scale operands: saturating versus wrapping results.
        fill(1, 1);
        load_x(0, NX-1);
        run_matrix(8'h40, 1'b0, 1'b0);

        // Identity-like A exposes lane packing and row ordering.
        fill(2, 2);
        load_x(0, NX-1);
        run_matrix(8'h80, 1'b0, 1'b0);

        // Back-pressure on row 1, then busy-time disturbance, then a repeat run.
        fill(3, 3);
        load_x(0, NX-1);
        run_matrix(ADDR_W'($urandom), 1'b1, 1'b0);
        run_matrix(8'h22, 1'b0, 1'b1);
        run_matrix(8'h22, 1'b0, 1'b0);

        for (int it = 0; it < 3; it++) begin
            fill(3 + (it % 2), 3);
            load_x(0, NX-1);
            run_matrix(ADDR_W'($urandom), 1'($urandom), 1'b0);
        end

        // Reset in the middle of row 2 must abort and clear the full flag.
        abort_run(8'h30);

        // Incomplete load blocks start; the final sample completes it.
        fill(4, 3);
        load_x(0, NX-2);
        ALU_en = 1'b1;
        @(posedge clk); #1;
        ALU_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored_partial", 128'(busy), 128'(0));
        load_x(NX-1, NX-1);
        run_matrix(8'h55, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
